// File: rtl/gtx_comma_align_if.sv
// Bus bundle for the GTX comma aligner: raw word and decoder error feedback in,
// aligned word plus lock/offset status out.
interface gtx_comma_align_if;
    logic [19:0] indata;
    logic [1:0]  err_in;
    logic [19:0] outdata;
    logic        aligned;
    logic        realign;
    logic [4:0]  offset;

    // master drives the raw stream (transceiver side), slave is the aligner
    modport master (
        output indata, err_in,
        input  outdata, aligned, realign, offset
    );
    modport slave (
        input  indata, err_in,
        output outdata, aligned, realign, offset
    );
endinterface

// File: rtl/gtx_comma_align.sv
// Comma-based word aligner for a 20-bit GTX stream with HUNT/VERIFY/LOCKED tracking.
// Define GTX_COMMA_ALIGN_ERRCHK_EN to let decoder errors count as bad cycles while locked.
module gtx_comma_align #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    gtx_comma_align_if.slave bus
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT4 = 4'(LOSS_COUNT);

    state_t      state_q, state_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  loss_q, loss_d;
    logic [4:0]  offset_q, offset_d;
    logic [19:0] indata_r_q;
    logic [19:0] outdata_q;
    logic        aligned_q;
    logic        realign_q;

    logic [39:0] window;
    logic [19:0] hit;
    logic        comma_found;
    logic [4:0]  comma_pos;
    logic        err_bad;
    logic        lock_bad;
    logic [3:0]  match_inc;
    logic [3:0]  loss_inc;

    // Older word sits in the low half so bit 0 stays the first bit received.
    assign window = {bus.indata, indata_r_q};

    for (genvar gi = 0; gi < 20; gi++) begin : g_det
        assign hit[gi] = (window[gi +: 7] == 7'b1111100) || (window[gi +: 7] == 7'b0000011);
    end

    always_comb begin
        comma_found = 1'b0;
        comma_pos   = 5'd0;
        for (int i = 19; i >= 0; i--) begin
            if (hit[i]) begin
                comma_found = 1'b1;
                comma_pos   = 5'(i);
            end
        end
    end

`ifdef GTX_COMMA_ALIGN_ERRCHK_EN
    assign err_bad = |bus.err_in;
`else
    logic unused_err_in;
    assign unused_err_in = ^bus.err_in;
    assign err_bad       = 1'b0;
`endif

    assign match_inc = match_q + 4'd1;
    assign loss_inc  = loss_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        loss_d   = loss_q;
        offset_d = offset_q;
        lock_bad = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (comma_found) begin
                    offset_d = comma_pos;
                    match_d  = 4'd1;
                    state_d  = VERIFY;
                end
            end
            VERIFY: begin
                if (comma_found) begin
                    if (comma_pos == offset_q) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_CNT4) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        offset_d = comma_pos;
                        match_d  = 4'd1;
                    end
                end
            end
            LOCKED: begin
                // A misplaced comma only accumulates loss; offset moves on the next HUNT hit.
                lock_bad = (comma_found && (comma_pos != offset_q)) || err_bad;
                if (lock_bad) begin
                    if (loss_inc == LOSS_CNT4) begin
                        state_d = HUNT;
                        match_d = 4'd0;
                        loss_d  = 4'd0;
                    end else begin
                        loss_d = loss_inc;
                    end
                end else if (comma_found) begin
                    loss_d = 4'd0;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HUNT;
            match_q    <= 4'd0;
            loss_q     <= 4'd0;
            offset_q   <= 5'd0;
            indata_r_q <= 20'd0;
            outdata_q  <= 20'd0;
            aligned_q  <= 1'b0;
            realign_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            loss_q     <= loss_d;
            offset_q   <= offset_d;
            indata_r_q <= bus.indata;
            // Extraction uses the offset in force this cycle, not the one being loaded.
            outdata_q  <= window[{1'b0, offset_q} +: 20];
            aligned_q  <= (state_d == LOCKED);
            realign_q  <= (offset_d != offset_q);
        end
    end

    assign bus.outdata = outdata_q;
    assign bus.aligned = aligned_q;
    assign bus.realign = realign_q;
    assign bus.offset  = offset_q;
endmodule
